// File: rtl/mplier_rr_arbiter.sv
// Round-robin arbiter in front of one shared N x N unsigned multiplier (IDLE -> CALC -> RESP).
// Optional macro MPLIER_ARB_ZERO_SKIP_EN: a zero operand bypasses CALC and answers with product 0.
module mplier_rr_arbiter #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*N-1:0]   req_mplier,
  input  logic [NREQ*N-1:0]   req_mcand,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IW-1:0]       rsp_id,
  output logic [2*N-1:0]      rsp_product
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

  state_e          state_q;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   id_q;
  logic [N-1:0]    mplier_q, mcand_q;
  logic [2*N-1:0]  rsp_product_q;
  logic            rsp_valid_q;

  logic            gnt_found;
  logic [IW-1:0]   gnt_idx;
  logic [IW:0]     cand_sum;
  logic [IW-1:0]   cand;
  logic [N-1:0]    sel_mplier, sel_mcand;
  logic [2*N-1:0]  mult;

  // First valid requester at or after ptr, wrapping past NREQ-1 back to 0.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand_sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (cand_sum >= (IW+1)'(NREQ))
        cand_sum = cand_sum - (IW+1)'(NREQ);
      cand = cand_sum[IW-1:0];
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready  = '0;
    sel_mplier = '0;
    sel_mcand  = '0;
    if (state_q == IDLE && gnt_found)
      req_ready[gnt_idx] = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_idx == IW'(k)) begin
        sel_mplier = req_mplier[k*N +: N];
        sel_mcand  = req_mcand[k*N +: N];
      end
    end
  end

  assign ptr_d = (id_q == IW'(NREQ-1)) ? '0 : id_q + IW'(1);

  // Datapath only ever sees the latched operands, so input changes after accept are harmless.
  assign mult = {{N{1'b0}}, mplier_q} * {{N{1'b0}}, mcand_q};

`ifdef MPLIER_ARB_ZERO_SKIP_EN
  logic sel_zero;
  assign sel_zero = (sel_mplier == '0) || (sel_mcand == '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      id_q          <= '0;
      mplier_q      <= '0;
      mcand_q       <= '0;
      rsp_product_q <= '0;
      rsp_valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            mplier_q <= sel_mplier;
            mcand_q  <= sel_mcand;
            id_q     <= gnt_idx;
`ifdef MPLIER_ARB_ZERO_SKIP_EN
            if (sel_zero) begin
              rsp_product_q <= '0;
              rsp_valid_q   <= 1'b1;
              state_q       <= RESP;
            end else begin
              state_q <= CALC;
            end
`else
            state_q <= CALC;
`endif
          end
        end
        CALC: begin
          rsp_product_q <= mult;
          rsp_valid_q   <= 1'b1;
          state_q       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ptr_q       <= ptr_d;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = id_q;
  assign rsp_product = rsp_product_q;

endmodule

// File: tb/tb_mplier_rr_arbiter.sv
// Directed bench for mplier_rr_arbiter: transaction-level reference model checked every cycle,
// plus literal expectations on response order, products and latency.
module tb_mplier_rr_arbiter;
  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int IW   = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*N-1:0]   req_mplier, req_mcand;
  logic                rsp_valid, rsp_ready;
  logic [IW-1:0]       rsp_id;
  logic [2*N-1:0]      rsp_product;

  always #5 clk = ~clk;

  mplier_rr_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mplier(req_mplier), .req_mcand(req_mcand),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_product(rsp_product)
  );

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: which requester is being served, what it must get, and whether it is visible yet.
  int          m_ptr  = 0;
  bit          m_busy = 1'b0;
  bit          m_rspv = 1'b0;
  int          m_id   = 0;
  logic [63:0] m_prod = '0;
  int          m_gnt;

  function automatic int grant_of(input logic [NREQ-1:0] v, input int p);
    for (int i = 0; i < NREQ; i++)
      if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  assign m_gnt = grant_of(req_valid, m_ptr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_busy <= 1'b0;
      m_rspv <= 1'b0;
      m_ptr  <= 0;
      m_id   <= 0;
    end else if (!m_busy) begin
      if (m_gnt >= 0) begin
        m_busy <= 1'b1;
        m_id   <= m_gnt;
        m_prod <= 64'(req_mplier[m_gnt*N +: N]) * 64'(req_mcand[m_gnt*N +: N]);
`ifdef MPLIER_ARB_ZERO_SKIP_EN
        if (req_mplier[m_gnt*N +: N] == 0 || req_mcand[m_gnt*N +: N] == 0) m_rspv <= 1'b1;
`endif
      end
    end else if (!m_rspv) begin
      m_rspv <= 1'b1;
    end else if (rsp_ready) begin
      m_busy <= 1'b0;
      m_rspv <= 1'b0;
      m_ptr  <= (m_id + 1) % NREQ;
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (started) begin
      chk("req_ready", 64'(req_ready), (!m_busy && m_gnt >= 0) ? (64'd1 << m_gnt) : 64'd0);
      chk("rsp_valid", 64'(rsp_valid), 64'(m_rspv));
      if (m_rspv) begin
        chk("rsp_id", 64'(rsp_id), 64'(m_id));
        chk("rsp_product", rsp_product, m_prod);
      end
    end
  end

  // Transaction monitor: accepted-to-visible latency and completed responses.
  int          acc_cyc = 0;
  logic        prev_v  = 1'b0;
  int          lat_q[$];
  int          rid_q[$];
  logic [63:0] rprod_q[$];

  always @(negedge clk) begin
    if (|(req_valid & req_ready)) acc_cyc <= cyc;
    if (rsp_valid === 1'b1 && prev_v !== 1'b1) lat_q.push_back(cyc - acc_cyc);
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      rid_q.push_back(int'(rsp_id));
      rprod_q.push_back(rsp_product);
    end
    prev_v <= rsp_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_q();
    lat_q.delete();
    rid_q.delete();
    rprod_q.delete();
  endtask

  task automatic set_req(input int k, input logic v, input logic [N-1:0] a, input logic [N-1:0] b);
    req_valid[k]         = v;
    req_mplier[k*N +: N] = a;
    req_mcand[k*N +: N]  = b;
  endtask

  task automatic wait_resp(input int cnt, input int bound, input string nm);
    int k = 0;
    while (rid_q.size() < cnt && k < bound) begin
      tick(1);
      k++;
    end
    if (rid_q.size() < cnt) begin
      total++;
      bad++;
      $display("FAIL %s timeout: got %0d responses want %0d", nm, rid_q.size(), cnt);
    end
  endtask

  task automatic wait_lat(input int cnt, input int bound, input string nm);
    int k = 0;
    while (lat_q.size() < cnt && k < bound) begin
      tick(1);
      k++;
    end
    if (lat_q.size() < cnt) begin
      total++;
      bad++;
      $display("FAIL %s timeout: got %0d valids want %0d", nm, lat_q.size(), cnt);
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_mplier = '0;
    req_mcand  = '0;
    rsp_ready  = 1'b1;
    @(posedge clk); #2;
    started = 1'b1;
    tick(1);

    // Reset state
    @(negedge clk);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_id", 64'(rsp_id), 64'd0);
    chk("reset rsp_product", rsp_product, 64'd0);
    chk("reset req_ready", 64'(req_ready), 64'd0);
    tick(1);

    // Max operands; inputs scrambled right after accept must not disturb the result
    set_req(0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rst = 1'b0;
    tick(1);
    set_req(0, 1'b0, 32'h1, 32'h2);
    wait_resp(1, 10, "single");
    if (rid_q.size() >= 1) begin
      chk("single id", 64'(rid_q[0]), 64'd0);
      chk("single product", rprod_q[0], 64'hFFFF_FFFE_0000_0001);
      chk("single latency", 64'(lat_q[0]), 64'd2);
    end
    tick(2);
    clear_q();

    // Fairness: all four held from reset
    rst = 1'b1;
    set_req(0, 1'b1, 3, 5);
    set_req(1, 1'b1, 7, 6);
    set_req(2, 1'b1, 10, 11);
    set_req(3, 1'b1, 2, 9);
    tick(2);
    rst = 1'b0;
    wait_resp(5, 40, "fair");
    req_valid = '0;
    if (rid_q.size() >= 5) begin
      chk("fair id0", 64'(rid_q[0]), 64'd0);
      chk("fair id1", 64'(rid_q[1]), 64'd1);
      chk("fair id2", 64'(rid_q[2]), 64'd2);
      chk("fair id3", 64'(rid_q[3]), 64'd3);
      chk("fair id4", 64'(rid_q[4]), 64'd0);
      chk("fair prod0", rprod_q[0], 64'd15);
      chk("fair prod1", rprod_q[1], 64'd42);
      chk("fair prod3", rprod_q[3], 64'd18);
    end
    tick(4);
    clear_q();

    // Back-pressure: ptr is 1, so req1 wins; others wait behind the stalled response
    rsp_ready = 1'b0;
    set_req(1, 1'b1, 100, 200);
    wait_lat(1, 10, "bp");
    set_req(1, 1'b0, 0, 0);
    set_req(0, 1'b1, 1, 1);
    set_req(2, 1'b1, 12, 12);
    for (int i = 0; i < 5; i++) begin
      chk("bp rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp rsp_id", 64'(rsp_id), 64'd1);
      chk("bp rsp_product", rsp_product, 64'd20000);
      chk("bp req_ready", 64'(req_ready), 64'd0);
      tick(1);
    end
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    chk("bp exit rsp_valid", 64'(rsp_valid), 64'd0);
    chk("bp exit grant", 64'(req_ready), 64'b0100);
    chk("model ptr after bp", 64'(m_ptr), 64'd2);
    req_valid = '0;
    rsp_ready = 1'b1;
    tick(2);
    clear_q();

    // Reset while in CALC abandons the request
    set_req(0, 1'b1, 5, 5);
    tick(1);
    req_valid = '0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst rsp_valid", 64'(rsp_valid), 64'd0);
    req_valid = 4'b0010;
    #1;
    chk("midrst idle grant", 64'(req_ready), 64'b0010);
    req_valid = '0;
    tick(10);
    chk("midrst no response", 64'(rid_q.size()), 64'd0);
    clear_q();

    // Zero operand
    set_req(2, 1'b1, 0, 32'h1234);
    tick(1);
    req_valid = '0;
    wait_resp(1, 10, "zero");
    if (rid_q.size() >= 1) begin
      chk("zero id", 64'(rid_q[0]), 64'd2);
      chk("zero product", rprod_q[0], 64'd0);
`ifdef MPLIER_ARB_ZERO_SKIP_EN
      chk("zero latency", 64'(lat_q[0]), 64'd1);
`else
      chk("zero latency", 64'(lat_q[0]), 64'd2);
`endif
    end
    tick(2);
    clear_q();

    // Wrap-around from ptr=3
    chk("model ptr before wrap", 64'(m_ptr), 64'd3);
    set_req(0, 1'b1, 4, 4);
    set_req(3, 1'b1, 9, 9);
    wait_resp(2, 20, "wrap");
    req_valid = '0;
    if (rid_q.size() >= 2) begin
      chk("wrap first id", 64'(rid_q[0]), 64'd3);
      chk("wrap second id", 64'(rid_q[1]), 64'd0);
      chk("wrap first prod", rprod_q[0], 64'd81);
      chk("wrap second prod", rprod_q[1], 64'd16);
    end
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
